piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in serial-out transmitter: the transmit end of the 1-bit serial link whose receive end is the 4-bit shift register on the `day6` board design. Accepts a WIDTH-bit word through a valid/ready handshake and drives it MSB-first onto one serial line. Each bit is held for 2^DIV_W clock cycles, produced by an internal clock-enable tick rather than a derived clock, so the line can be watched on board LEDs. The intended use drives the receiver's `x_i` from the same board clock. Bit timing is set only by the tick period.

## Interface
- `WIDTH`, default 4: word width in bits; must be ≥ 2.
- `DIV_W`, default 25: tick divider width; the bit period N = 2^DIV_W cycles.
- `clk`  in  1: the only clock; all logic is on its rising edge.
- `reset`  in  1: synchronous, active-high reset. It is sampled on `clk` only.
- `load_valid_i`  in  1: a word is offered on `load_data_i`.
- `load_data_i`  in  WIDTH: the word to transmit.
- `load_ready_o`  out  1: the block can accept a word.
- `x_o`  out  1: serial data line.
- `x_valid_o`  out  1: high while `x_o` carries a word bit.
- `done_o`  out  1: one-cycle pulse when a word has finished.

## Operation
- The FSM has two states, IDLE and SHIFT.
- IDLE:
  - `load_ready_o`=1, `x_o`=0, `x_valid_o`=0.
  - On `load_valid_i`&&`load_ready_o`: `shreg`<=`load_data_i`, `bit_cnt`<=0, divider cleared to 0, state goes to SHIFT.
- SHIFT:
  - `load_ready_o`=0.
  - `x_o`=`shreg[WIDTH-1]`, `x_valid_o`=1.
  - On each tick, if `bit_cnt`==WIDTH-1: state goes to IDLE and `done_o`<=1 for the next cycle.
  - On each tick otherwise: `shreg`<=`{shreg[WIDTH-2:0],1'b0}` and `bit_cnt`++.
- Tick: `tick`=1 when the divider equals 2^DIV_W−1. The divider wraps to 0 naturally and also clears on load acceptance.
- The divider free-runs in IDLE. Because it clears on load, the phase of every word is deterministic.
- Widths:
  - `bit_cnt` is $clog2(WIDTH) bits.
  - The divider is DIV_W bits and wraps modulo 2^DIV_W with no overflow flag.
- `load_valid_i` while in SHIFT is ignored (ready is low). The word is not captured and the current word is not disturbed.
- `load_data_i` is sampled only on the accepting edge. Later changes to it have no effect.
- Reset, including mid-word: next cycle the block is in IDLE, `shreg`=0, `bit_cnt`=0, divider=0, `x_o`=0, `x_valid_o`=0, `done_o`=0, `load_ready_o`=1. No `done_o` pulse is issued for the aborted word.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- Take acceptance as the edge ending cycle 0:
  - Bit WIDTH−1 (the MSB) is on `x_o` during cycles 1..N.
  - Bit k is on `x_o` during cycles (WIDTH−1−k)·N+1 .. (WIDTH−k)·N.
- Word occupancy is exactly WIDTH·N cycles.
- At cycle WIDTH·N+1: `done_o`=1 for one cycle, `load_ready_o`=1, `x_valid_o`=0.
- A new word can be accepted in that same cycle (WIDTH·N+1). Back-to-back words are therefore separated by one idle cycle.
- Loopback: a `day6`-style receiver clocked on this block's tick, with `x_i`=`x_o`, holds the transmitted word in `sr_o` after WIDTH ticks.

## Structure
- Package `serial_link_pkg`:
  - `typedef enum logic {IDLE, SHIFT} ser_state_t;`
  - Default localparams for WIDTH and DIV_W, shared with the receive side.
- Sub-module `tick_gen #(DIV_W)`:
  - Inputs: `clk`, `reset`, `clear_i`.
  - Output: `tick_o`, the one-cycle pulse at terminal count.
  - It is reused by the receive side in place of its derived clock.
- Top level: FSM, shift register, bit counter, output registers.

## Test plan
All scenarios run with DIV_W=2 (N=4) and WIDTH=4.
- Reset -> `load_ready_o`=1, `x_o`=0, `x_valid_o`=0, `done_o`=0.
- Load 4'b1011 at cycle 0 -> `x_o` over cycles 1–16 is 1,0,1,1, each held 4 cycles. `x_valid_o`=1 over 1–16. `done_o`=1 only at cycle 17, with `load_ready_o`=1 at 17.
- Load 4'b0110 with `load_valid_i` held high and `load_data_i` switched to 4'b1111 at cycle 3 -> `x_o` is 0,1,1,0. The second word is accepted at cycle 17 and its MSB appears at cycle 18.
- Load 4'b1111, then assert `reset` at cycle 7 -> at cycle 8 all outputs are at reset values and no `done_o` pulse occurs. A load of 4'b1000 at cycle 8 transmits 1,0,0,0 from cycle 9.
- Loads of 4'b0000 and 4'b1111 -> `x_o` constant for 16 cycles. `x_valid_o` frames the word, and `done_o` pulses once per word.
- Loopback into a receiver shifting on `tick_o` -> `sr_o`=4'b1011 after the 4th tick following acceptance of 4'b1011.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared definitions for the 1-bit serial link (transmit and receive ends).
//   ser_state_t : transmitter FSM state encoding
//   SER_WIDTH   : default word width in bits
//   SER_DIV_W   : default tick divider width (bit period = 2**SER_DIV_W cycles)
package serial_link_pkg;

  typedef enum logic {IDLE, SHIFT} ser_state_t;

  localparam int SER_WIDTH = 4;
  localparam int SER_DIV_W = 25;

endpackage

// File: rtl/tick_gen.sv
// Clock-enable tick generator: free-running DIV_W-bit divider that pulses
// tick_o for one cycle at terminal count (all ones), then wraps to zero.
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset, divider to 0
//   clear_i : restart the divider at 0 on the next edge (phase alignment)
//   tick_o  : one-cycle pulse when the divider equals 2**DIV_W-1
module tick_gen #(
  parameter int DIV_W = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic tick_o
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (clear_i) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick_o = &div_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter. Accepts a WIDTH-bit word through a
// valid/ready handshake and drives it MSB-first on x_o, each bit held for
// one tick period (2**DIV_W cycles).
// Ports:
//   clk          : clock, rising edge
//   reset        : synchronous active-high reset (aborts any word, no done)
//   load_valid_i : a word is offered on load_data_i
//   load_data_i  : word to transmit, sampled only on the accepting edge
//   load_ready_o : high in IDLE, block can accept a word
//   x_o          : serial data line (0 when idle)
//   x_valid_o    : high while x_o carries a word bit
//   done_o       : one-cycle pulse after the last bit period of a word
module piso_serializer
  import serial_link_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH,
  parameter int DIV_W = SER_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic             load_ready_o,
  output logic             x_o,
  output logic             x_valid_o,
  output logic             done_o
);

  localparam int CNT_W = $clog2(WIDTH);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             done_q, done_d;

  logic tick;
  logic accept;
  logic last_bit;

  assign accept   = (state_q == IDLE) && load_valid_i;
  assign last_bit = (bit_cnt_q == CNT_W'(WIDTH - 1));

  // Clearing the divider on acceptance gives every word the same phase:
  // the first tick lands exactly N cycles after the accepting edge.
  tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .clear_i (accept),
    .tick_o  (tick)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (tick && last_bit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, decoded from registered state only
  always_comb begin
    load_ready_o = 1'b0;
    x_o          = 1'b0;
    x_valid_o    = 1'b0;
    case (state_q)
      IDLE: begin
        load_ready_o = 1'b1;
      end
      SHIFT: begin
        x_o       = shreg_q[WIDTH-1];
        x_valid_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Shift register, bit counter and done pulse
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    if (accept) begin
      shreg_d   = load_data_i;
      bit_cnt_d = '0;
    end else if ((state_q == SHIFT) && tick) begin
      if (last_bit) begin
        done_d = 1'b1;
      end else begin
        shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
    end
  end

  assign done_o = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer with WIDTH=4, DIV_W=2 (N=4 cycles/bit).
// Cycle numbering: the accepting edge ends cycle 0; signals are driven and
// sampled 1 time unit after each rising edge.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid_i;
  logic [3:0] load_data_i;
  logic       load_ready_o;
  logic       x_o;
  logic       x_valid_o;
  logic       done_o;

  int n_tests = 0;
  int n_fail  = 0;

  piso_serializer #(
    .WIDTH (4),
    .DIV_W (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid_i (load_valid_i),
    .load_data_i  (load_data_i),
    .load_ready_o (load_ready_o),
    .x_o          (x_o),
    .x_valid_o    (x_valid_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  // Receiver model of the day6-style shift register, clocked by the tick.
  logic [3:0] rx_sr = 4'b0000;
  always @(posedge clk) begin
    if (dut.u_tick.tick_o) rx_sr <= {rx_sr[2:0], x_o};
  end

  typedef struct {
    logic [3:0]  data;
    logic [15:0] exp_seq;  // x_o for cycles 1..16, cycle 1 in bit 15
  } vec_t;

  vec_t vecs [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    load_valid_i = 1'b0;
    load_data_i  = 4'b0000;
    step();
    step();
    reset = 1'b0;
  endtask

  // Offer a word in the current cycle (cycle 0) and step to cycle 1.
  task automatic load_word(input string name, input logic [3:0] data, input bit keep_valid);
    load_valid_i = 1'b1;
    load_data_i  = data;
    check({name, " ready@0"}, load_ready_o, 1'b1);
    step();
    if (!keep_valid) load_valid_i = 1'b0;
  endtask

  // Starting in cycle 1, check the 16 bit-cycles and the done cycle 17.
  // If sw_cyc != 0, load_data_i is changed to sw_data during that cycle.
  task automatic run_word(input string name, input logic [15:0] exp_seq,
                          input int sw_cyc, input logic [3:0] sw_data);
    for (int c = 1; c <= 16; c++) begin
      check($sformatf("%s x@%0d", name, c), x_o, exp_seq[16-c]);
      check($sformatf("%s xv@%0d", name, c), x_valid_o, 1'b1);
      check($sformatf("%s done@%0d", name, c), done_o, 1'b0);
      check($sformatf("%s rdy@%0d", name, c), load_ready_o, 1'b0);
      if (c == sw_cyc) load_data_i = sw_data;
      step();
    end
    check({name, " done@17"}, done_o, 1'b1);
    check({name, " rdy@17"}, load_ready_o, 1'b1);
    check({name, " xv@17"}, x_valid_o, 1'b0);
    check({name, " x@17"}, x_o, 1'b0);
  endtask

  initial begin
    int ticks;

    vecs[0] = '{data: 4'b1011, exp_seq: 16'hF0FF};
    vecs[1] = '{data: 4'b0000, exp_seq: 16'h0000};
    vecs[2] = '{data: 4'b1111, exp_seq: 16'hFFFF};
    vecs[3] = '{data: 4'b0110, exp_seq: 16'h0FF0};
    vecs[4] = '{data: 4'b1000, exp_seq: 16'hF000};

    // Reset values
    do_reset();
    check("rst ready", load_ready_o, 1'b1);
    check("rst x", x_o, 1'b0);
    check("rst xv", x_valid_o, 1'b0);
    check("rst done", done_o, 1'b0);

    // Table-driven words; done must be a single pulse
    for (int i = 0; i < 5; i++) begin
      load_word($sformatf("vec%0d", i), vecs[i].data, 1'b0);
      run_word($sformatf("vec%0d", i), vecs[i].exp_seq, 0, 4'b0000);
      step();
      check($sformatf("vec%0d done@18", i), done_o, 1'b0);
      check($sformatf("vec%0d xv@18", i), x_valid_o, 1'b0);
    end

    // Valid held high, data changed mid-word; second word accepted at 17
    do_reset();
    load_word("hold", 4'b0110, 1'b1);
    run_word("hold", 16'h0FF0, 3, 4'b1111);
    step();
    load_valid_i = 1'b0;
    check("hold2 x@18", x_o, 1'b1);
    check("hold2 xv@18", x_valid_o, 1'b1);
    check("hold2 rdy@18", load_ready_o, 1'b0);
    check("hold2 done@18", done_o, 1'b0);
    for (int c = 19; c <= 33; c++) step();
    check("hold2 x@33", x_o, 1'b1);
    step();
    check("hold2 done@34", done_o, 1'b1);

    // Reset mid-word, then a new word right after
    do_reset();
    load_word("abort", 4'b1111, 1'b0);
    for (int c = 1; c < 7; c++) step();
    check("abort x@7", x_o, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort ready@8", load_ready_o, 1'b1);
    check("abort x@8", x_o, 1'b0);
    check("abort xv@8", x_valid_o, 1'b0);
    check("abort done@8", done_o, 1'b0);
    load_word("after", 4'b1000, 1'b0);
    run_word("after", 16'hF000, 0, 4'b0000);
    step();

    // Loopback into a receiver shifting on the tick
    do_reset();
    load_word("loop", 4'b1011, 1'b0);
    ticks = 0;
    for (int c = 1; c <= 40 && ticks < 4; c++) begin
      if (dut.u_tick.tick_o) ticks++;
      step();
    end
    check("loop ticks", ticks, 4);
    check("loop sr", rx_sr, 4'b1011);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
